// File: rtl/jtframe_sdram_pkg.sv
// Shared constants for the SDRAM response model: ring bit positions, latency bounds, read-word order.
package jtframe_sdram_pkg;

   localparam int unsigned LAT_MIN   = 5;
   localparam int unsigned LAT_MAX   = 16;
   localparam int unsigned RING_IDLE = 0;

   // 1: data_read = {word[addr+1], word[addr]} exactly as mem_din delivers it
   localparam bit DATA_LITTLE_ENDIAN = 1'b1;

   typedef enum logic {
      OP_ACCESS  = 1'b0,
      OP_REFRESH = 1'b1
   } op_e;

   function automatic int unsigned ring_rd_bit(input int unsigned lat);
      return lat - 2;
   endfunction

   function automatic int unsigned ring_last_bit(input int unsigned lat);
      return lat - 1;
   endfunction

endpackage

// File: rtl/jtframe_sdram_stats.sv
// Saturating usage counters for the SDRAM response model (built only with JTFRAME_SDRAM_STATS_EN).
module jtframe_sdram_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        idle,
   input  logic        sdram_req,
   input  logic        line_clr,
   output logic [31:0] idle_cnt,
   output logic [31:0] total_cnt,
   output logic [15:0] line_idle
);

   logic clr_q;
   logic idle_hit;
   logic clr_rise;

   always_comb begin
      idle_hit = idle & ~sdram_req;
      clr_rise = line_clr & ~clr_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         clr_q     <= 1'b0;
         idle_cnt  <= 32'd0;
         total_cnt <= 32'd0;
         line_idle <= 16'd0;
      end else begin
         clr_q <= line_clr;
         if (!(&total_cnt))
            total_cnt <= total_cnt + 32'd1;
         if (idle_hit && !(&idle_cnt))
            idle_cnt <= idle_cnt + 32'd1;
         // a clear edge wins over a same-cycle idle count
         if (clr_rise)
            line_idle <= 16'd0;
         else if (idle_hit && !(&line_idle))
            line_idle <= line_idle + 16'd1;
      end
   end

endmodule

// File: rtl/jtframe_sdram_resp.sv
// Fixed-latency SDRAM response model sequenced by a one-hot ring; also runs refresh slots.
// Optional statistics counters are built when JTFRAME_SDRAM_STATS_EN is defined.
module jtframe_sdram_resp
   import jtframe_sdram_pkg::*;
#(
   parameter int unsigned LATENCY = 6,
   parameter int unsigned AW      = 22
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sdram_req,
   input  logic [AW-1:0] sdram_addr,
   input  logic          sdram_rnw,
   input  logic [15:0]   data_write,
   input  logic          refresh_en,
   output logic          sdram_ack,
   output logic          data_rdy,
   output logic [31:0]   data_read,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [31:0]   mem_din,
   output logic          mem_we,
   output logic [15:0]   mem_dout,
   output logic          busy
`ifdef JTFRAME_SDRAM_STATS_EN
   ,
   input  logic          line_clr,
   output logic [31:0]   idle_cnt,
   output logic [31:0]   total_cnt,
   output logic [15:0]   line_idle
`endif
);

   localparam int unsigned RD_BIT   = ring_rd_bit(LATENCY);
   localparam int unsigned LAST_BIT = ring_last_bit(LATENCY);

   if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("jtframe_sdram_resp: LATENCY outside supported range");
   end

   logic [LATENCY-1:0] ring;
   logic [LATENCY-1:0] ring_nxt;
   logic [LATENCY-1:0] ring_rot;
   logic               accept;
   logic               start_ref;
   logic               is_acc;
   logic               last;
   logic               rdy_nxt;
   logic               rd_nxt;
   logic               we_nxt;
   logic               busy_nxt;
   logic               rnw_q;
   op_e                op_q;

   // Ring register; bit RING_IDLE set means idle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ring <= {{(LATENCY-1){1'b0}}, 1'b1};
      else     ring <= ring_nxt;
   end

   // Next ring position and the strobes for the following cycle
   always_comb begin
      ring_rot  = {ring[LATENCY-2:0], ring[LATENCY-1]};
      ring_nxt  = ring;
      accept    = 1'b0;
      start_ref = 1'b0;
      if (ring[RING_IDLE]) begin
         if (sdram_req) begin
            accept   = 1'b1;
            ring_nxt = ring_rot;
         end else if (refresh_en) begin
            start_ref = 1'b1;
            ring_nxt  = ring_rot;
         end
      end else begin
         ring_nxt = ring_rot;
      end
      is_acc   = (op_q == OP_ACCESS);
      last     = ring[LAST_BIT];
      rdy_nxt  = last & is_acc;
      rd_nxt   = ring_nxt[RD_BIT] & is_acc & rnw_q;
      we_nxt   = ring_nxt[LAST_BIT] & is_acc & ~rnw_q;
      busy_nxt = ~ring_nxt[RING_IDLE] | last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sdram_ack <= 1'b0;
         data_rdy  <= 1'b0;
         data_read <= 32'd0;
         mem_addr  <= '0;
         mem_rd    <= 1'b0;
         mem_we    <= 1'b0;
         mem_dout  <= 16'd0;
         busy      <= 1'b0;
         rnw_q     <= 1'b0;
         op_q      <= OP_ACCESS;
      end else begin
         sdram_ack <= accept;
         data_rdy  <= rdy_nxt;
         mem_rd    <= rd_nxt;
         mem_we    <= we_nxt;
         busy      <= busy_nxt;
         if (accept) begin
            mem_addr <= sdram_addr;
            rnw_q    <= sdram_rnw;
            mem_dout <= data_write;
            op_q     <= OP_ACCESS;
         end else if (start_ref) begin
            op_q <= OP_REFRESH;
         end
         // mem_din is valid in the cycle after mem_rd, i.e. the last ring slot
         if (rdy_nxt && rnw_q)
            data_read <= DATA_LITTLE_ENDIAN ? mem_din : {mem_din[15:0], mem_din[31:16]};
      end
   end

`ifdef JTFRAME_SDRAM_STATS_EN
   jtframe_sdram_stats u_stats (
      .clk       (clk),
      .rst       (rst),
      .idle      (ring[RING_IDLE]),
      .sdram_req (sdram_req),
      .line_clr  (line_clr),
      .idle_cnt  (idle_cnt),
      .total_cnt (total_cnt),
      .line_idle (line_idle)
   );
`endif

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed self-checking bench for jtframe_sdram_resp (LATENCY=6, AW=22) with a one-cycle backing memory.
module tb_jtframe_sdram_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        sdram_req;
   logic [21:0] sdram_addr;
   logic        sdram_rnw;
   logic [15:0] data_write;
   logic        refresh_en;
   logic        sdram_ack;
   logic        data_rdy;
   logic [31:0] data_read;
   logic [21:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_din = 32'd0;
   logic        mem_we;
   logic [15:0] mem_dout;
   logic        busy;
`ifdef JTFRAME_SDRAM_STATS_EN
   logic        line_clr;
   logic [31:0] idle_cnt;
   logic [31:0] total_cnt;
   logic [15:0] line_idle;
`endif

   int total = 0;
   int bad   = 0;

   logic [31:0] mem_val = 32'd0;
   int          rd_cnt  = 0;
   int          we_cnt  = 0;
   logic [21:0] rd_addr = 22'd0;
   logic [21:0] we_addr = 22'd0;
   logic [15:0] we_data = 16'd0;

   jtframe_sdram_resp #(.LATENCY(6), .AW(22)) dut (
      .clk        (clk),
      .rst        (rst),
      .sdram_req  (sdram_req),
      .sdram_addr (sdram_addr),
      .sdram_rnw  (sdram_rnw),
      .data_write (data_write),
      .refresh_en (refresh_en),
      .sdram_ack  (sdram_ack),
      .data_rdy   (data_rdy),
      .data_read  (data_read),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_din    (mem_din),
      .mem_we     (mem_we),
      .mem_dout   (mem_dout),
      .busy       (busy)
`ifdef JTFRAME_SDRAM_STATS_EN
      ,
      .line_clr   (line_clr),
      .idle_cnt   (idle_cnt),
      .total_cnt  (total_cnt),
      .line_idle  (line_idle)
`endif
   );

   always #5 clk = ~clk;

   // Backing memory: answers a read one cycle later, records every strobe
   always @(posedge clk) begin
      if (mem_rd) begin
         mem_din <= mem_val;
         rd_cnt  <= rd_cnt + 1;
         rd_addr <= mem_addr;
      end
      if (mem_we) begin
         we_cnt  <= we_cnt + 1;
         we_addr <= mem_addr;
         we_data <= mem_dout;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Advance until data_rdy, counting cycles from the given start index
   task automatic wait_rdy(input int start, output int cyc);
      cyc = start;
      while (!data_rdy && cyc < 30) begin
         tick();
         cyc++;
      end
   endtask

   int cyc;
   int we0;
   int rd0;
   int acks;
   int ack_at [3];
   int nb;
   int nr;
   int na;

   initial begin
      rst        = 1'b1;
      sdram_req  = 1'b0;
      sdram_addr = 22'd0;
      sdram_rnw  = 1'b1;
      data_write = 16'd0;
      refresh_en = 1'b0;
`ifdef JTFRAME_SDRAM_STATS_EN
      line_clr   = 1'b0;
`endif
      repeat (3) tick();
      check("rst_ack",  64'(sdram_ack), 64'd0);
      check("rst_rdy",  64'(data_rdy),  64'd0);
      check("rst_data", 64'(data_read), 64'd0);
      check("rst_busy", 64'(busy),      64'd0);
      check("rst_strb", 64'({mem_rd, mem_we}), 64'd0);

      // Read
      rst        = 1'b0;
      sdram_req  = 1'b1;
      sdram_addr = 22'h3B0000;
      sdram_rnw  = 1'b1;
      mem_val    = 32'h11223344;
      tick();
      check("rd_ack",  64'(sdram_ack), 64'd1);
      check("rd_busy", 64'(busy),      64'd1);
      sdram_req = 1'b0;
      tick();
      check("rd_ack_pulse", 64'(sdram_ack), 64'd0);
      wait_rdy(2, cyc);
      check("rd_lat",   64'(cyc),       64'd6);
      check("rd_data",  64'(data_read), 64'h11223344);
      check("rd_addr",  64'(rd_addr),   64'h3B0000);
      check("rd_count", 64'(rd_cnt),    64'd1);
      tick();
      check("rd_rdy_pulse", 64'(data_rdy), 64'd0);
      check("rd_busy_end",  64'(busy),     64'd0);

      // Write
      we0        = we_cnt;
      sdram_req  = 1'b1;
      sdram_rnw  = 1'b0;
      sdram_addr = 22'h000010;
      data_write = 16'hBEEF;
      tick();
      check("wr_ack", 64'(sdram_ack), 64'd1);
      sdram_req = 1'b0;
      wait_rdy(1, cyc);
      check("wr_lat",   64'(cyc),          64'd6);
      check("wr_count", 64'(we_cnt - we0), 64'd1);
      check("wr_addr",  64'(we_addr),      64'h10);
      check("wr_data",  64'(we_data),      64'hBEEF);
      check("wr_keep",  64'(data_read),    64'h11223344);
      tick();

      // Back-to-back with request held high
      acks       = 0;
      sdram_req  = 1'b1;
      sdram_rnw  = 1'b1;
      sdram_addr = 22'h000100;
      mem_val    = 32'hA5A55A5A;
      for (int c = 1; c <= 18; c++) begin
         tick();
         if (sdram_ack) begin
            if (acks < 3) ack_at[acks] = c;
            acks++;
         end
         if (c == 2) sdram_addr = 22'h000BAD;
         if (c == 4) check("b2b_nolatch", 64'(mem_addr), 64'h100);
         if (c == 18) sdram_req = 1'b0;
      end
      check("b2b_acks", 64'(acks),      64'd3);
      check("b2b_ack0", 64'(ack_at[0]), 64'd1);
      check("b2b_ack1", 64'(ack_at[1]), 64'd7);
      check("b2b_ack2", 64'(ack_at[2]), 64'd13);
      check("b2b_last_rdy", 64'(data_rdy), 64'd1);
      tick();
      check("b2b_idle", 64'(busy), 64'd0);

      // Request wins over refresh; read at the top of the address space
      sdram_req  = 1'b1;
      refresh_en = 1'b1;
      sdram_addr = 22'h3FFFFF;
      mem_val    = 32'hCAFE1234;
      tick();
      check("cont_ack", 64'(sdram_ack), 64'd1);
      sdram_req = 1'b0;
      wait_rdy(1, cyc);
      check("cont_lat",  64'(cyc),       64'd6);
      check("cont_data", 64'(data_read), 64'hCAFE1234);
      check("cont_addr", 64'(rd_addr),   64'h3FFFFF);

      // Refresh starts in this idle cycle (refresh_en=1, no request)
      rd0 = rd_cnt;
      we0 = we_cnt;
      tick();
      refresh_en = 1'b0;
      nb = 0; nr = 0; na = 0;
      for (int i = 0; i < 20; i++) begin
         if (!busy) break;
         nb++;
         if (data_rdy)  nr++;
         if (sdram_ack) na++;
         tick();
      end
      check("ref_busy", 64'(nb), 64'd6);
      check("ref_rdy",  64'(nr), 64'd0);
      check("ref_ack",  64'(na), 64'd0);
      check("ref_strb", 64'((rd_cnt - rd0) + (we_cnt - we0)), 64'd0);

      // Reset in ring bit 3 of a write
      we0        = we_cnt;
      sdram_req  = 1'b1;
      sdram_rnw  = 1'b0;
      sdram_addr = 22'h000055;
      data_write = 16'h1234;
      tick();
      check("rw_ack", 64'(sdram_ack), 64'd1);
      sdram_req = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      #1;
      check("rw_outs", 64'({sdram_ack, data_rdy, busy, mem_rd, mem_we}), 64'd0);
      check("rw_data", 64'(data_read), 64'd0);
      check("rw_regs", 64'({mem_addr, mem_dout}), 64'd0);
      tick();
      tick();
      rst        = 1'b0;
      sdram_req  = 1'b1;
      sdram_rnw  = 1'b1;
      sdram_addr = 22'h000020;
      mem_val    = 32'h0F0FF0F0;
      tick();
      check("rw_rel_ack", 64'(sdram_ack), 64'd1);
      sdram_req = 1'b0;
      wait_rdy(1, cyc);
      check("rw_rel_lat",  64'(cyc),       64'd6);
      check("rw_rel_data", 64'(data_read), 64'h0F0FF0F0);
      check("rw_no_we",    64'(we_cnt - we0), 64'd0);

`ifdef JTFRAME_SDRAM_STATS_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (100) tick();
      check("st_idle", 64'(idle_cnt), 64'd100);
      line_clr = 1'b1;
      tick();
      check("st_line", 64'(line_idle), 64'd0);
      check("st_total", 64'(total_cnt), 64'd101);
      line_clr = 1'b0;
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
